// File: rtl/mem_bank_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_bank_array
// Purpose  : Banked single-port SRAM model with byte strobes, a fixed-latency
//            response pipeline and error reporting for out-of-range accesses
//            and unsupported atomics.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bank_array #(
    parameter int NumBanks     = 1,
    parameter int AddrWidth    = 32,
    parameter int DataWidth    = 32,
    parameter int WordsPerBank = 256,
    parameter int Latency      = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumBanks-1:0]                  mem_req_i,
    output logic [NumBanks-1:0]                  mem_gnt_o,
    input  logic [NumBanks*AddrWidth-1:0]        mem_addr_i,
    input  logic [NumBanks-1:0]                  mem_we_i,
    input  logic [DataWidth-1:0]                 mem_wdata_i,
    input  logic [DataWidth/8-1:0]               mem_strb_i,
    input  logic [NumBanks*6-1:0]                mem_atop_i,
    input  logic [NumBanks-1:0]                  stall_i,
    output logic [NumBanks-1:0]                  mem_rvalid_o,
    output logic [DataWidth-1:0]                 mem_rdata_o,
    output logic [NumBanks-1:0]                  mem_err_o
);

    localparam int c_bank_w  = DataWidth / NumBanks;
    localparam int c_bytes   = c_bank_w / 8;
    localparam int c_off_w   = (c_bytes > 1) ? $clog2(c_bytes) : 0;
    localparam int c_idx_w   = (WordsPerBank > 1) ? $clog2(WordsPerBank) : 1;
    localparam logic [AddrWidth:0] c_words = WordsPerBank;

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        // Per-bank request decode
        logic [AddrWidth-1:0] addr;
        logic [AddrWidth-1:0] idx;
        logic [c_idx_w-1:0]   widx;
        logic [c_bank_w-1:0]  wdata;
        logic [c_bytes-1:0]   strb;
        logic [5:0]           atop;
        logic                 accept;
        logic                 out_of_range;
        logic                 err;
        logic [c_bank_w-1:0]  rd_data;

        // Storage is deliberately left unreset
        logic [c_bank_w-1:0]  mem_q [WordsPerBank];

        // Response pipeline, stage Latency-1 drives the outputs
        logic                 valid_d [Latency];
        logic                 valid_q [Latency];
        logic [c_bank_w-1:0]  rdata_d [Latency];
        logic [c_bank_w-1:0]  rdata_q [Latency];
        logic                 err_d   [Latency];
        logic                 err_q   [Latency];

        assign addr  = mem_addr_i[b*AddrWidth +: AddrWidth];
        assign wdata = mem_wdata_i[b*c_bank_w +: c_bank_w];
        assign strb  = mem_strb_i[b*c_bytes +: c_bytes];
        assign atop  = mem_atop_i[b*6 +: 6];

        // Low byte-offset bits are dropped; only the word index matters
        assign idx          = addr >> c_off_w;
        assign widx         = idx[c_idx_w-1:0];
        assign out_of_range = ({1'b0, idx} >= c_words);
        assign err          = out_of_range | (atop != 6'd0);

        // Grant masks stall and reset; a grant implies acceptance at the edge
        assign mem_gnt_o[b] = mem_req_i[b] & ~stall_i[b] & rst_ni;
        assign accept       = mem_gnt_o[b];

        // Read data sampled in the acceptance cycle; writes and errors return zero
        always_comb begin
            rd_data = '0;
            if (accept && !mem_we_i[b] && !err) begin
                rd_data = mem_q[widx];
            end
        end

        // Byte-strobed storage write for clean accepted writes
        always_ff @(posedge clk_i) begin
            if (accept && mem_we_i[b] && !err) begin
                for (int i = 0; i < c_bytes; i++) begin
                    if (strb[i]) begin
                        mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end

        // Next-state of the response shift register
        always_comb begin
            for (int k = 0; k < Latency; k++) begin
                valid_d[k] = 1'b0;
                rdata_d[k] = '0;
                err_d[k]   = 1'b0;
            end
            valid_d[0] = accept;
            rdata_d[0] = rd_data;
            err_d[0]   = accept & err;
            for (int k = 1; k < Latency; k++) begin
                valid_d[k] = valid_q[k-1];
                rdata_d[k] = rdata_q[k-1];
                err_d[k]   = err_q[k-1];
            end
        end

        // Response pipeline registers; reset drops every in-flight response
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                for (int k = 0; k < Latency; k++) begin
                    valid_q[k] <= 1'b0;
                    rdata_q[k] <= '0;
                    err_q[k]   <= 1'b0;
                end
            end else begin
                for (int k = 0; k < Latency; k++) begin
                    valid_q[k] <= valid_d[k];
                    rdata_q[k] <= rdata_d[k];
                    err_q[k]   <= err_d[k];
                end
            end
        end

        assign mem_rvalid_o[b]                      = valid_q[Latency-1];
        assign mem_rdata_o[b*c_bank_w +: c_bank_w] = rdata_q[Latency-1];
        assign mem_err_o[b]                         = err_q[Latency-1];
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bank_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bank_array
// Purpose  : Self-checking bench for mem_bank_array. Two instances share the
//            clock: A (1 bank, latency 1) and B (2 banks, latency 3). Their
//            three banks are handled as uniform 32-bit lanes against a
//            word-array memory model and per-lane expected-response queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bank_array;

    localparam int c_lanes = 3;
    localparam int c_words = 256;

    typedef struct packed {
        logic [31:0] due;
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n;
    logic rst_b_n;

    // Lane-level stimulus
    logic        req   [c_lanes];
    logic        we    [c_lanes];
    logic [31:0] addr  [c_lanes];
    logic [31:0] wdata [c_lanes];
    logic [3:0]  strb  [c_lanes];
    logic [5:0]  atop  [c_lanes];
    logic        stall [c_lanes];

    // Instance A ports
    logic        a_gnt, a_rvalid, a_err;
    logic [31:0] a_rdata;
    // Instance B ports
    logic [1:0]  b_gnt, b_rvalid, b_err;
    logic [63:0] b_rdata;

    mem_bank_array #(
        .NumBanks(1), .AddrWidth(32), .DataWidth(32), .WordsPerBank(256), .Latency(1)
    ) u_dut_a (
        .clk_i        (clk),
        .rst_ni       (rst_a_n),
        .mem_req_i    (req[0]),
        .mem_gnt_o    (a_gnt),
        .mem_addr_i   (addr[0]),
        .mem_we_i     (we[0]),
        .mem_wdata_i  (wdata[0]),
        .mem_strb_i   (strb[0]),
        .mem_atop_i   (atop[0]),
        .stall_i      (stall[0]),
        .mem_rvalid_o (a_rvalid),
        .mem_rdata_o  (a_rdata),
        .mem_err_o    (a_err)
    );

    mem_bank_array #(
        .NumBanks(2), .AddrWidth(32), .DataWidth(64), .WordsPerBank(256), .Latency(3)
    ) u_dut_b (
        .clk_i        (clk),
        .rst_ni       (rst_b_n),
        .mem_req_i    ({req[2], req[1]}),
        .mem_gnt_o    (b_gnt),
        .mem_addr_i   ({addr[2], addr[1]}),
        .mem_we_i     ({we[2], we[1]}),
        .mem_wdata_i  ({wdata[2], wdata[1]}),
        .mem_strb_i   ({strb[2], strb[1]}),
        .mem_atop_i   ({atop[2], atop[1]}),
        .stall_i      ({stall[2], stall[1]}),
        .mem_rvalid_o (b_rvalid),
        .mem_rdata_o  (b_rdata),
        .mem_err_o    (b_err)
    );

    // Reference model state
    logic [31:0] mem_m  [c_lanes][c_words];
    resp_t       exp_q  [c_lanes][$];
    int          lat    [c_lanes];
    logic        in_rst [c_lanes];
    int          edge_cnt;
    int          n_checks;
    int          n_errors;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_cnt, got, exp);
        end
    endtask

    function automatic logic get_gnt(input int l);
        return (l == 0) ? a_gnt : b_gnt[l-1];
    endfunction

    function automatic logic get_rvalid(input int l);
        return (l == 0) ? a_rvalid : b_rvalid[l-1];
    endfunction

    function automatic logic get_err(input int l);
        return (l == 0) ? a_err : b_err[l-1];
    endfunction

    function automatic logic [31:0] get_rdata(input int l);
        return (l == 0) ? a_rdata : b_rdata[32*(l-1) +: 32];
    endfunction

    task automatic set_lane(input int l, input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s, input logic [5:0] at,
                            input logic st);
        req[l] = r; we[l] = w; addr[l] = a; wdata[l] = d;
        strb[l] = s; atop[l] = at; stall[l] = st;
    endtask

    task automatic idle_all();
        for (int l = 0; l < c_lanes; l++) set_lane(l, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    endtask

    // One clock: check grants, run the model for the coming edge, then check responses
    task automatic step();
        #1;
        for (int l = 0; l < c_lanes; l++) begin
            logic        rl;
            logic        g;
            int unsigned idx;
            logic        e;
            resp_t       r;
            rl  = (l == 0) ? rst_a_n : rst_b_n;
            g   = req[l] & ~stall[l] & rl;
            chk_eq($sformatf("gnt[%0d]", l), {63'd0, get_gnt(l)}, {63'd0, g});
            in_rst[l] = ~rl;
            if (!rl) exp_q[l].delete();
            if (g) begin
                idx    = addr[l] / 4;
                e      = (idx >= c_words) || (atop[l] != 6'd0);
                r.due  = edge_cnt + 1 + lat[l] - 1;
                r.err  = e;
                r.data = 32'd0;
                if (!e && we[l]) begin
                    for (int i = 0; i < 4; i++)
                        if (strb[l][i]) mem_m[l][idx][8*i +: 8] = wdata[l][8*i +: 8];
                end else if (!e) begin
                    r.data = mem_m[l][idx];
                end
                exp_q[l].push_back(r);
            end
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        for (int l = 0; l < c_lanes; l++) begin
            if (exp_q[l].size() > 0 && exp_q[l][0].due == edge_cnt) begin
                resp_t r;
                r = exp_q[l].pop_front();
                chk_eq($sformatf("rvalid[%0d]", l), {63'd0, get_rvalid(l)}, 64'd1);
                chk_eq($sformatf("rdata[%0d]", l), {32'd0, get_rdata(l)}, {32'd0, r.data});
                chk_eq($sformatf("err[%0d]", l), {63'd0, get_err(l)}, {63'd0, r.err});
            end else begin
                chk_eq($sformatf("rvalid_idle[%0d]", l), {63'd0, get_rvalid(l)}, 64'd0);
            end
            if (in_rst[l]) begin
                chk_eq($sformatf("rst_rdata[%0d]", l), {32'd0, get_rdata(l)}, 64'd0);
                chk_eq($sformatf("rst_err[%0d]", l), {63'd0, get_err(l)}, 64'd0);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        edge_cnt = 0;
        lat[0] = 1; lat[1] = 3; lat[2] = 3;
        for (int l = 0; l < c_lanes; l++) in_rst[l] = 1'b0;
        idle_all();
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        @(negedge clk);

        // Reset: requests present but grants must stay low
        for (int l = 0; l < c_lanes; l++) set_lane(l, 1'b1, 1'b0, 32'h10, '0, 4'hF, '0, 1'b0);
        repeat (3) step();
        idle_all();
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        step();

        // Fill every word of every lane with random data
        for (int w = 0; w < c_words; w++) begin
            for (int l = 0; l < c_lanes; l++)
                set_lane(l, 1'b1, 1'b1, 32'(w * 4), $urandom, 4'hF, '0, 1'b0);
            step();
        end
        idle_all();
        repeat (4) step();

        // Lane 0: full write, read, partial write, read
        set_lane(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, '0, 1'b0); step();
        set_lane(0, 1'b1, 1'b0, 32'h10, '0, 4'h0, '0, 1'b0);            step();
        set_lane(0, 1'b1, 1'b1, 32'h10, 32'h11223344, 4'h5, '0, 1'b0); step();
        set_lane(0, 1'b1, 1'b0, 32'h13, '0, 4'h0, '0, 1'b0);            step();
        // Out-of-range write, read back, atomic read, zero-strobe write
        set_lane(0, 1'b1, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, '0, 1'b0); step();
        set_lane(0, 1'b1, 1'b0, 32'h10, '0, 4'h0, '0, 1'b0);            step();
        set_lane(0, 1'b1, 1'b0, 32'h10, '0, 4'h0, 6'h20, 1'b0);         step();
        set_lane(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'h0, '0, 1'b0);         step();
        set_lane(0, 1'b1, 1'b0, 32'h3FC, '0, 4'h0, '0, 1'b0);           step();
        // Stall for three cycles, then release
        set_lane(0, 1'b1, 1'b0, 32'h10, '0, 4'h0, '0, 1'b1);
        repeat (3) step();
        stall[0] = 1'b0; step();
        idle_all();
        repeat (3) step();

        // Instance B: back-to-back reads on bank 0 with concurrent writes on bank 1
        for (int i = 0; i < 4; i++) begin
            set_lane(1, 1'b1, 1'b0, 32'(i * 4), '0, 4'h0, '0, 1'b0);
            set_lane(2, 1'b1, 1'b1, 32'(i * 4), $urandom, 4'($urandom_range(0, 15)), '0, 1'b0);
            step();
        end
        idle_all();
        repeat (5) step();

        // Reset with two responses in flight, then confirm storage survives
        set_lane(1, 1'b1, 1'b1, 32'h20, 32'hA5A55A5A, 4'hF, '0, 1'b0); step();
        set_lane(1, 1'b1, 1'b0, 32'h20, '0, 4'h0, '0, 1'b0);            step();
        set_lane(1, 1'b1, 1'b0, 32'h24, '0, 4'h0, '0, 1'b0);            step();
        idle_all();
        rst_b_n = 1'b0;
        repeat (2) step();
        rst_b_n = 1'b1;
        repeat (5) step();
        set_lane(1, 1'b1, 1'b0, 32'h20, '0, 4'h0, '0, 1'b0);            step();
        idle_all();
        repeat (4) step();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < c_lanes; l++) begin
                logic [31:0] a;
                if ($urandom_range(0, 9) == 0) a = $urandom_range(1024, 4095);
                else if ($urandom_range(0, 49) == 0) a = $urandom;
                else a = $urandom_range(0, 1023);
                set_lane(l, ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1, a, $urandom,
                         4'($urandom_range(0, 15)),
                         ($urandom_range(0, 15) == 0) ? 6'($urandom_range(1, 63)) : 6'd0,
                         ($urandom_range(0, 3) == 0));
            end
            rst_a_n = ($urandom_range(0, 99) != 0);
            rst_b_n = ($urandom_range(0, 99) != 0);
            step();
        end
        idle_all();
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        repeat (6) step();

        for (int l = 0; l < c_lanes; l++)
            chk_eq($sformatf("drained[%0d]", l), 64'(exp_q[l].size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
